// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot-time program loader.
interface imem_loader_if #(
  parameter int XLEN = 32
) ();
  logic            start;
  logic            in_valid;
  logic [7:0]      in_data;
  logic            in_ready;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            core_hold;
  logic            done;
  logic            error;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, core_hold, done, error
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, core_hold, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: length-prefixed little-endian byte stream to word writes.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int XLEN     = 32,
  parameter int MEM_SIZE = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus
);
  localparam int IDXW = $clog2(MEM_SIZE) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM = 3'd5,
`endif
    S_ERR  = 3'd4
  } state_e;

  function automatic logic is_active(input state_e s);
`ifdef IMEM_LOADER_CHECKSUM_EN
    return (s == S_LEN) || (s == S_DATA) || (s == S_CSUM);
`else
    return (s == S_LEN) || (s == S_DATA);
`endif
  endfunction

  state_e          state_q, state_d;
  logic [31:0]     n_q, n_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [IDXW-1:0] widx_q, widx_d;
  logic [31:0]     word_q, word_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            ready_q, ready_d;
  logic            hold_q, hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  logic            xfer_s;
  logic [31:0]     word_next_s;
  logic [31:0]     n_next_s;

  // New bytes enter at the top, so after four shifts the first byte sits in bits [7:0].
  assign xfer_s      = bus.in_valid && ready_q;
  assign word_next_s = {bus.in_data, word_q[31:8]};
  assign n_next_s    = {bus.in_data, n_q[31:8]};

  assign bus.in_ready  = ready_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.core_hold = hold_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    bcnt_d  = bcnt_q;
    widx_d  = widx_q;
    word_d  = word_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    error_d = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          state_d = S_LEN;
          n_d     = 32'd0;
          bcnt_d  = 2'd0;
          widx_d  = '0;
          word_d  = 32'd0;
          done_d  = 1'b0;
          error_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = 8'd0;
`endif
        end else begin
          // DONE entered with the final write in flight; done follows one cycle later.
          done_d = (state_q == S_DONE);
        end
      end
      S_LEN: begin
        if (xfer_s) begin
          n_d    = n_next_s;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            if (n_next_s == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
              done_d  = 1'b1;
`endif
            end else if (n_next_s > 32'(MEM_SIZE)) begin
              state_d = S_ERR;
              error_d = 1'b1;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            state_d = S_LEN;
          end
        end else begin
          state_d = S_LEN;
        end
      end
      S_DATA: begin
        if (xfer_s) begin
          word_d = word_next_s;
          bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.in_data;
`endif
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = XLEN'({widx_q, 2'b00});
            wdata_d = XLEN'(word_next_s);
            widx_d  = widx_q + IDXW'(1);
            if ((32'(widx_q) + 32'd1) == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
            end else begin
              state_d = S_DATA;
            end
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer_s) begin
          if ((csum_q ^ bus.in_data) == 8'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end else begin
          state_d = S_CSUM;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = is_active(state_d);
    hold_d  = is_active(state_d) || we_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= 32'd0;
      bcnt_q  <= 2'd0;
      widx_q  <= '0;
      word_q  <= 32'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      ready_q <= 1'b0;
      hold_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      bcnt_q  <= bcnt_d;
      widx_q  <= widx_d;
      word_q  <= word_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      error_q <= error_d;
      ready_q <= ready_d;
      hold_q  <= hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end
endmodule
